// File: rtl/pc_unit_pkg.sv
// pc_unit_pkg: shared PC-unit state encodings and IF-stage/debug default constants
package pc_unit_pkg;
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_STEP   = 2'd2,
    ST_HALTED = 2'd3
  } pc_state_e;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
  localparam int unsigned DEFAULT_INCR = 4;
endpackage

// File: rtl/pc_fetch_counter.sv
// pc_fetch_counter: saturating counter with enable for counting advancing fetch cycles
module pc_fetch_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  output logic [CNT_W-1:0] count
);
  always_ff @(posedge clk) begin
    if (rst) count <= '0;
    else if (en && !(&count)) count <= count + 1'b1;
  end
endmodule

// File: rtl/pc_unit.sv
// pc_unit: parametrised PC with next-PC selection, debug run/step/halt FSM, misaligned trap and fetch counter
module pc_unit
  import pc_unit_pkg::*;
#(
  parameter int              PC_W       = 32,
  parameter logic [PC_W-1:0] RESET_PC   = PC_W'(DEFAULT_RESET_PC),
  parameter int unsigned     INCR       = DEFAULT_INCR,
  parameter int              ALIGN_BITS = 2,
  parameter int              CNT_W      = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_run,
  input  logic             i_step,
  input  logic             i_stall,
  input  logic             i_redirect,
  input  logic [PC_W-1:0]  i_redirect_pc,
  input  logic             i_halt_req,
  output logic [PC_W-1:0]  o_pc,
  output logic [PC_W-1:0]  o_pc_next_seq,
  output logic             o_fetch_valid,
  output logic [1:0]       o_state,
  output logic             o_misaligned,
  output logic [CNT_W-1:0] o_fetch_count
);
  localparam logic [PC_W-1:0] ALIGN_MASK = PC_W'((64'd1 << ALIGN_BITS) - 64'd1);
  pc_state_e state, state_d;
  logic [PC_W-1:0] pc_d;
  logic active, aligned, advance, trap;
  assign active        = (state == ST_RUN) || (state == ST_STEP);
  assign aligned       = (i_redirect_pc & ALIGN_MASK) == '0;
  // halt_req outranks everything; a redirect (good or bad) outranks stall
  assign advance       = active && !i_halt_req && (i_redirect ? aligned : !i_stall);
  assign trap          = active && !i_halt_req && i_redirect && !aligned;
  assign o_pc_next_seq = o_pc + PC_W'(INCR);
  assign o_fetch_valid = active;
  assign o_state       = state;
  assign pc_d          = !advance ? o_pc : i_redirect ? i_redirect_pc : o_pc_next_seq;
  always_comb begin
    state_d = state;
    case (state)
      ST_IDLE: state_d = i_run ? ST_RUN : i_step ? ST_STEP : ST_IDLE;
      ST_RUN:  state_d = (i_halt_req || trap) ? ST_HALTED : ST_RUN;
      ST_STEP: state_d = (i_halt_req || trap) ? ST_HALTED : advance ? ST_IDLE : ST_STEP;
      default: state_d = ST_HALTED;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_IDLE;
      o_pc         <= RESET_PC;
      o_misaligned <= 1'b0;
    end else begin
      state        <= state_d;
      o_pc         <= pc_d;
      o_misaligned <= o_misaligned | trap;
    end
  end
  pc_fetch_counter #(.CNT_W(CNT_W)) u_cnt (
    .clk  (clk),
    .rst  (rst),
    .en   (advance),
    .count(o_fetch_count)
  );
endmodule

// File: doc/pc_unit.md
Name: pc_unit

Overview:
- Parametrised program-counter unit; successor to the plain PC register at the head of the IF stage of the pipelined MIPS core.
- Adds configurable width, reset vector and increment.
- Adds internal next-PC selection: sequential, redirect, or hold on stall.
- Adds a debug run/step/halt state machine, a misaligned-redirect trap and a saturating fetch counter for the debug unit.

Parameters:
PC_W, 32, PC width in bits
RESET_PC, 0, PC value loaded on reset (first fetch address)
INCR, 4, sequential increment in bytes
ALIGN_BITS, 2, low PC bits that must be zero on a redirect target
CNT_W, 32, fetch counter width

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  synchronous reset, active-high
i_run  in  1  debug: start continuous execution (level, sampled in IDLE)
i_step  in  1  debug: execute one fetch (sampled in IDLE)
i_stall  in  1  hazard unit: hold PC this cycle
i_redirect  in  1  branch/jump resolved taken, load i_redirect_pc
i_redirect_pc  in  PC_W  redirect target
i_halt_req  in  1  HALT instruction decoded
o_pc  out  PC_W  current fetch address (registered)
o_pc_next_seq  out  PC_W  o_pc + INCR, combinational, modulo 2^PC_W
o_fetch_valid  out  1  o_pc is a valid fetch this cycle
o_state  out  2  IDLE=0, RUN=1, STEP=2, HALTED=3
o_misaligned  out  1  sticky: a misaligned redirect was trapped
o_fetch_count  out  CNT_W  number of advancing cycles since reset

Behaviour:
- Reset (rst=1 at an edge, any state, any other inputs): o_pc=RESET_PC, state=IDLE, o_misaligned=0, o_fetch_count=0. A mid-operation reset discards pending step/redirect.
- o_fetch_valid = (state==RUN || state==STEP); combinational from state only.
- State transitions:
  - IDLE: i_run → RUN; else i_step → STEP (i_run wins if both are high); PC holds; redirect, stall and halt_req are ignored.
  - RUN: i_halt_req → HALTED; stays RUN otherwise; i_run/i_step are ignored.
  - STEP: an advancing cycle → IDLE; a stalled, non-redirect cycle stays STEP; i_halt_req → HALTED.
  - HALTED: terminal until rst; PC and counter frozen; all inputs ignored.
- PC update, only in RUN/STEP, evaluated in this priority:
  1. i_halt_req: PC holds, not an advancing cycle, even if redirect or stall is also high.
  2. i_redirect with i_redirect_pc[ALIGN_BITS-1:0]==0: PC ← i_redirect_pc; advancing. Redirect wins over i_stall.
  3. i_redirect misaligned: PC holds, o_misaligned←1, state → HALTED; not advancing.
  4. i_stall: PC holds; not advancing.
  5. Otherwise: PC ← PC + INCR (wraps 2^PC_W−INCR → 0); advancing.
- Update latency: one cycle; new o_pc is visible after the edge.
- Fetch counter: +1 on every advancing cycle; saturates at 2^CNT_W−1 and never wraps.
- o_pc_next_seq tracks o_pc in all states, including IDLE and HALTED.

Decomposition:
- Shared package holds:
  - state encodings: ST_IDLE, ST_RUN, ST_STEP, ST_HALTED;
  - the 2-bit state typedef;
  - the default RESET_PC/INCR constants used by the IF stage and the debug unit.
- One natural sub-module: pc_fetch_counter, a CNT_W saturating counter with enable.
- Next-PC mux and FSM stay in pc_unit.

Test Plan:
- Reset then i_run=1 one cycle, no stall → o_state=RUN; o_pc sequence 0,4,8,12; o_fetch_count=3 after 3 advancing edges.
- RUN with i_stall=1 for 2 cycles at o_pc=8 → o_pc stays 8 both cycles, count unchanged; i_redirect=1 with target 0x40 while i_stall=1 → o_pc=0x40 next cycle.
- IDLE, i_step pulse with i_stall=1 for the first 2 cycles → state STEP for 3 cycles, o_pc 0→4 on the third edge, then IDLE, o_fetch_valid=0, count=1.
- RUN, i_redirect=1 with target 0x42 → o_misaligned=1, state HALTED, o_pc unchanged; later i_run/i_step ignored; rst=1 clears to o_pc=0, IDLE, o_misaligned=0.
- RUN with i_halt_req=1 and i_redirect=1 (target 0x80) in the same cycle → HALTED, o_pc unchanged; rst asserted mid-RUN with i_redirect high → o_pc=RESET_PC, IDLE.
- PC_W=8, CNT_W=3, start at o_pc=0xF8 in RUN → o_pc 0xFC, 0x00 (wrap); after 9 advancing cycles o_fetch_count=7 (saturated).
